// File: rtl/rrns_2nrm_pkg.sv
// Shared definitions for the 2NRM residue number system encoder and decoder.
//
// Contents:
//   - moduli constants M257, M256, M61, M59, M55, M53
//   - field widths (W_*) and LSB offsets (L_*) inside the 41-bit residue vector
//   - RES_W (packed residue vector width) and DATA_W (data word width)
//   - per-modulus lookup tables for generate loops
//   - enc_state_t: encoder FSM states IDLE / SHIFT
package rrns_2nrm_pkg;

    localparam int DATA_W  = 16;
    localparam int RES_W   = 41;
    localparam int NUM_MOD = 6;

    localparam int M257 = 257;
    localparam int M256 = 256;
    localparam int M61  = 61;
    localparam int M59  = 59;
    localparam int M55  = 55;
    localparam int M53  = 53;

    // Field widths: each residue field is exactly ceil(log2(m)) bits wide.
    localparam int W_R257 = 9;
    localparam int W_R256 = 8;
    localparam int W_R61  = 6;
    localparam int W_R59  = 6;
    localparam int W_R55  = 6;
    localparam int W_R53  = 6;

    // LSB offsets of each field in the packed vector.
    localparam int L_R257 = 32;
    localparam int L_R256 = 24;
    localparam int L_R61  = 18;
    localparam int L_R59  = 12;
    localparam int L_R55  = 6;
    localparam int L_R53  = 0;

    // Tables indexed by modulus number, for generate loops.
    localparam int MOD_TAB [NUM_MOD] = '{M257, M256, M61, M59, M55, M53};
    localparam int W_TAB   [NUM_MOD] = '{W_R257, W_R256, W_R61, W_R59, W_R55, W_R53};
    localparam int LSB_TAB [NUM_MOD] = '{L_R257, L_R256, L_R61, L_R59, L_R55, L_R53};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } enc_state_t;

endpackage

// File: rtl/mod_serial_acc.sv
// Bit-serial modular accumulator: acc <- (2*acc + bit_in) mod M, MSB first.
//
// Parameters:
//   M  modulus
//   W  accumulator width, ceil(log2(M)); the intermediate sum is W+1 bits
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   clr     synchronous clear of the accumulator (has priority over en)
//   en      consume bit_in this cycle
//   bit_in  next data bit, MSB first
//   acc     current residue of the bits consumed so far
module mod_serial_acc #(
    parameter int M = 257,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         bit_in,
    output logic [W-1:0] acc
);

    localparam logic [W:0] M_V = (W+1)'(M);

    logic [W:0]   t;
    logic [W-1:0] acc_next;

    // acc < M guarantees t <= 2M-1, so a single conditional subtract
    // brings the result back into [0, M).
    always_comb begin
        t        = {acc, bit_in};
        acc_next = t[W-1:0];
        if (t >= M_V) begin
            acc_next = W'(t - M_V);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/encoder_2nrm_serial.sv
// 2NRM encoder: converts a 16-bit word into the 41-bit packed residue vector
// over moduli {257, 256, 61, 59, 55, 53} using six bit-serial accumulators
// (one data bit per clock, MSB first). 17 cycles per word.
//
// Optional build macro: ENC_2NRM_SELFCHECK_EN
//   Keeps a copy of the captured word and compares the serial residues with
//   combinational data % m at completion; check_err pulses with valid on any
//   difference. Simulation / bring-up only. Without it check_err is 0.
//
// Parameters:
//   CNT_W         bit-counter width, 2**CNT_W must exceed DATA_W
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         encode request, sampled only in IDLE
//   data_in       word to encode, captured on the accepted start edge
//   busy          high while encoding; start is ignored meanwhile
//   residues_out  [40:32]=r257 [31:24]=r256 [23:18]=r61 [17:12]=r59
//                 [11:6]=r55 [5:0]=r53; held until the next completion
//   valid         one-cycle pulse when residues_out updates
//   check_err     self-check mismatch flag, coincident with valid
module encoder_2nrm_serial
    import rrns_2nrm_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic [RES_W-1:0]  residues_out,
    output logic              valid,
    output logic              check_err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    enc_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              busy_reg, busy_next;
    logic              valid_reg, valid_next;
    logic [RES_W-1:0]  hold_reg, hold_next;
    logic              acc_clr;
    logic              acc_en;
    logic              accept;

    wire  [RES_W-1:0]  res_acc;

    // ---------------- next-state / control ----------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        busy_next  = busy_reg;
        valid_next = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        accept     = 1'b0;
        // The accumulators hold the final residues only during the valid
        // cycle (a back-to-back start clears them on the next edge), so the
        // result is latched into hold_reg at the end of that cycle.
        hold_next  = valid_reg ? res_acc : hold_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    shift_next = data_in;
                    acc_clr    = 1'b1;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                acc_en     = 1'b1;
                shift_next = {shift_reg[DATA_W-2:0], 1'b0};
                cnt_next   = cnt_reg + 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    cnt_next   = '0;
                    valid_next = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
            busy_reg  <= busy_next;
            valid_reg <= valid_next;
            hold_reg  <= hold_next;
        end
    end

`ifdef ENC_2NRM_SELFCHECK_EN
    logic [DATA_W-1:0] copy_reg;
    wire  [NUM_MOD-1:0] mism;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copy_reg <= '0;
        end else if (accept) begin
            copy_reg <= data_in;
        end
    end
`endif

    // ---------------- six modular accumulators ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MOD; gi++) begin : g_mod
            localparam int M = MOD_TAB[gi];
            localparam int W = W_TAB[gi];
            localparam int L = LSB_TAB[gi];

            logic [W-1:0] acc;

            mod_serial_acc #(
                .M (M),
                .W (W)
            ) u_acc (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr    (acc_clr),
                .en     (acc_en),
                .bit_in (shift_reg[DATA_W-1]),
                .acc    (acc)
            );

            assign res_acc[L +: W] = acc;

`ifdef ENC_2NRM_SELFCHECK_EN
            assign mism[gi] = (acc != W'(copy_reg % M));
`endif
        end
    endgenerate

    // ---------------- outputs ----------------
    assign busy         = busy_reg;
    assign valid        = valid_reg;
    assign residues_out = valid_reg ? res_acc : hold_reg;

`ifdef ENC_2NRM_SELFCHECK_EN
    assign check_err = valid_reg & (|mism);
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_2nrm_serial.sv
// Self-checking bench for encoder_2nrm_serial.
module tb_encoder_2nrm_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] data_in;
    wire         busy;
    wire  [40:0] residues_out;
    wire         valid;
    wire         check_err;

    int          checks   = 0;
    int          failures = 0;
    int          n_valid  = 0;
    int          n_expect = 0;
    logic [40:0] exp_q [$];
    logic [40:0] last_res = '0;

    encoder_2nrm_serial dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .data_in      (data_in),
        .busy         (busy),
        .residues_out (residues_out),
        .valid        (valid),
        .check_err    (check_err)
    );

    always #5 clk = ~clk;

    // Reference residue vector computed directly with the % operator.
    function automatic logic [40:0] ref_res(input logic [15:0] d);
        int v;
        v = int'(d);
        return {9'(v % 257), 8'(v % 256), 6'(v % 61), 6'(v % 59), 6'(v % 55), 6'(v % 53)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard monitor: pops one expected vector per valid pulse and
    // checks that the output holds its value between completions.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_res = '0;
        end else if (valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                chk("valid_unexpected", valid, 1'b0);
            end else begin
                logic [40:0] e;
                e = exp_q.pop_front();
                chk("residues", residues_out, e);
                chk("check_err", check_err, 1'b0);
                chk("busy_at_valid", busy, 1'b0);
                $display("txn: residues=%h expected=%h", residues_out, e);
                last_res = e;
            end
        end else begin
            chk("hold", residues_out, last_res);
        end
    end

    // Drive a start pulse with data d; returns just after the accept edge.
    task automatic accept_word(input logic [15:0] d);
        start   = 1'b1;
        data_in = d;
        exp_q.push_back(ref_res(d));
        n_expect++;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
    endtask

    // Count rising edges until valid is seen, bounded.
    task automatic wait_valid(output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            n = k;
            if (valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("valid_timeout", valid, 1'b1);
    endtask

    initial begin
        int n;
        rst_n   = 1'b1;
        start   = 1'b0;
        data_in = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_valid", valid, 1'b0);
        chk("reset_check_err", check_err, 1'b0);
        chk("reset_residues", residues_out, 41'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero word: latency and all-zero residues.
        accept_word(16'h0000);
        wait_valid(n);
        chk("latency_0000", n, 16);
        chk("plan_0000", residues_out, 41'd0);
        @(posedge clk);
        #1;
        chk("valid_one_cycle", valid, 1'b0);

        // All-ones word.
        accept_word(16'hFFFF);
        wait_valid(n);
        chk("latency_ffff", n, 16);
        chk("plan_ffff", residues_out, {9'd0, 8'd255, 6'd21, 6'd45, 6'd30, 6'd27});

        // Decimal 1000.
        @(posedge clk);
        #1;
        accept_word(16'd1000);
        wait_valid(n);
        chk("plan_1000", residues_out, {9'd229, 8'd232, 6'd24, 6'd56, 6'd10, 6'd46});

        // Start while busy is dropped.
        @(posedge clk);
        #1;
        accept_word(16'h1234);
        repeat (4) @(posedge clk);
        #1;
        start   = 1'b1;
        data_in = 16'hBEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_ignore", busy, 1'b1);
        wait_valid(n);
        chk("latency_ignore", n, 11);
        repeat (20) @(posedge clk);
        #1;
        chk("valid_count_ignore", n_valid, n_expect);

        // Reset in the middle of an encode.
        accept_word(16'h5A5A);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        n_expect--;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_valid", valid, 1'b0);
        chk("abort_residues", residues_out, 41'd0);
        chk("abort_check_err", check_err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("valid_count_abort", n_valid, n_expect);
        accept_word(16'h00FF);
        wait_valid(n);
        chk("latency_after_abort", n, 16);

        // Start held high: one word every 17 cycles.
        @(posedge clk);
        #1;
        start   = 1'b1;
        data_in = 16'h1234;
        exp_q.push_back(ref_res(16'h1234));
        n_expect++;
        @(posedge clk);
        #1;
        data_in = 16'h8001;
        exp_q.push_back(ref_res(16'h8001));
        n_expect++;
        wait_valid(n);
        chk("held_latency0", n, 16);
        @(posedge clk);
        #1;
        chk("held_busy1", busy, 1'b1);
        data_in = 16'h0101;
        exp_q.push_back(ref_res(16'h0101));
        n_expect++;
        wait_valid(n);
        chk("held_latency1", n, 16);
        @(posedge clk);
        #1;
        chk("held_busy2", busy, 1'b1);
        start   = 1'b0;
        data_in = 16'hAAAA;
        wait_valid(n);
        chk("held_latency2", n, 16);

        // Random words.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            accept_word(16'($urandom_range(0, 65535)));
            wait_valid(n);
            chk("latency_rand", n, 16);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("valid_count_final", n_valid, n_expect);
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
